// File: rtl/alu_bist_driver.sv
// ALU BIST initiator: LFSR operand generator, op sequencer and MISR compactor with golden compare.
// Optional `ALU_BIST_GOLDEN_EN adds a per-vector reference ALU check (mismatch/failIndex outputs).
//
// state   | meaning
// IDLE    | waiting for start after reset
// APPLY   | drive a/b/op for vector vecCount
// CAPTURE | fold aluResult into MISR, advance LFSR
// DONE    | run complete, results held until next start
module alu_bist_driver #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_VECTORS = 64,
    parameter logic [WIDTH-1:0] LFSR_SEED   = WIDTH'(32'hACE12345),
    parameter logic [WIDTH-1:0] GOLDEN_SIG  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [2:0]       op,
    input  logic [WIDTH-1:0] aluResult,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
`ifdef ALU_BIST_GOLDEN_EN
    output logic             mismatch,
    output logic [15:0]      failIndex,
`endif
    output logic [15:0]      vecCount
);

    typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;

    localparam int HALF = WIDTH / 2;
    // Taps follow x^32+x^22+x^2+x+1; narrower builds fold the high taps into the middle.
    localparam int               MISR_TAP  = (WIDTH > 22) ? 21 : HALF;
    localparam int               LFSR_HI   = (WIDTH > 22) ? 22 : HALF + 1;
    localparam logic [WIDTH-1:0] LFSR_TAPS = (WIDTH'(1) << LFSR_HI) | WIDTH'(7);
    localparam logic [15:0]      LAST_VEC  = 16'(NUM_VECTORS - 1);

    state_t           state_q, state_n;
    logic [WIDTH-1:0] lfsr_q, lfsr_n;
    logic [WIDTH-1:0] misr_q, misr_n, misr_upd;
    logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
    logic [2:0]       op_q, op_n, op_idx_q, op_idx_n;
    logic [15:0]      vec_q, vec_n;
    logic             busy_q, busy_n, done_q, done_n, pass_q, pass_n;
    logic             misr_fb;
    logic             ok_n;

    assign misr_fb  = misr_q[WIDTH-1] ^ misr_q[MISR_TAP] ^ misr_q[1] ^ misr_q[0];
    assign misr_upd = {misr_q[WIDTH-2:0], misr_fb} ^ aluResult;

`ifdef ALU_BIST_GOLDEN_EN
    logic             mismatch_q, mismatch_n;
    logic [15:0]      fail_idx_q, fail_idx_n;
    logic [WIDTH-1:0] ref_result;

    always_comb begin
        ref_result = '0;
        case (op_q)
            3'd0:    ref_result = a_q + b_q;
            3'd1:    ref_result = a_q - b_q;
            3'd2:    ref_result = a_q & b_q;
            3'd3:    ref_result = a_q | b_q;
            3'd4:    ref_result = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: ref_result = '0;
        endcase
    end

    assign mismatch  = mismatch_q;
    assign failIndex = fail_idx_q;
`endif

    always_comb begin
        state_n  = state_q;
        lfsr_n   = lfsr_q;
        misr_n   = misr_q;
        a_n      = a_q;
        b_n      = b_q;
        op_n     = op_q;
        op_idx_n = op_idx_q;
        vec_n    = vec_q;
        busy_n   = busy_q;
        done_n   = done_q;
        pass_n   = pass_q;
        ok_n     = 1'b1;
`ifdef ALU_BIST_GOLDEN_EN
        mismatch_n = mismatch_q;
        fail_idx_n = fail_idx_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    lfsr_n   = LFSR_SEED;
                    misr_n   = '0;
                    vec_n    = '0;
                    op_idx_n = '0;
                    busy_n   = 1'b1;
                    done_n   = 1'b0;
                    pass_n   = 1'b0;
`ifdef ALU_BIST_GOLDEN_EN
                    mismatch_n = 1'b0;
                    fail_idx_n = '0;
`endif
                    state_n  = APPLY;
                end
            end
            APPLY: begin
                a_n     = lfsr_q;
                b_n     = {lfsr_q[HALF-1:0], lfsr_q[WIDTH-1:HALF]};
                op_n    = op_idx_q;
                state_n = CAPTURE;
            end
            CAPTURE: begin
                misr_n   = misr_upd;
                lfsr_n   = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? LFSR_TAPS : '0);
                op_idx_n = (op_idx_q == 3'd4) ? 3'd0 : op_idx_q + 3'd1;
`ifdef ALU_BIST_GOLDEN_EN
                if (ref_result != aluResult) begin
                    mismatch_n = 1'b1;
                    if (!mismatch_q)
                        fail_idx_n = vec_q;
                end
                ok_n = ~mismatch_n;
`endif
                if (vec_q == LAST_VEC) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (misr_upd == GOLDEN_SIG) && ok_n;
                    state_n = DONE;
                end else begin
                    vec_n   = vec_q + 16'd1;
                    state_n = APPLY;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lfsr_q   <= LFSR_SEED;
            misr_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            op_idx_q <= '0;
            vec_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
`ifdef ALU_BIST_GOLDEN_EN
            mismatch_q <= 1'b0;
            fail_idx_q <= '0;
`endif
        end else begin
            state_q  <= state_n;
            lfsr_q   <= lfsr_n;
            misr_q   <= misr_n;
            a_q      <= a_n;
            b_q      <= b_n;
            op_q     <= op_n;
            op_idx_q <= op_idx_n;
            vec_q    <= vec_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            pass_q   <= pass_n;
`ifdef ALU_BIST_GOLDEN_EN
            mismatch_q <= mismatch_n;
            fail_idx_q <= fail_idx_n;
`endif
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign op        = op_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_q;
    assign vecCount  = vec_q;

endmodule

// File: tb/tb_alu_bist_driver.sv
// Directed bench for alu_bist_driver: 5-vector runs against a behavioural ALU with fault injection.
// Builds with or without ALU_BIST_GOLDEN_EN.
module tb_alu_bist_driver;

    localparam logic [31:0] SEED = 32'hACE12345;
    localparam int          NV   = 5;

    function automatic logic [31:0] m_alu(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o);
        case (o)
            3'd0:    return x + y;
            3'd1:    return x - y;
            3'd2:    return x & y;
            3'd3:    return x | y;
            3'd4:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_lfsr(input logic [31:0] x);
        return {x[30:0], 1'b0} ^ (x[31] ? 32'h00400007 : 32'h0);
    endfunction

    function automatic logic [31:0] m_rot(input logic [31:0] x);
        return {x[15:0], x[31:16]};
    endfunction

    function automatic logic [31:0] m_sig(input int n, input bit stuck, input int bad_vec);
        logic [31:0] l, m, r;
        l = SEED;
        m = 32'h0;
        for (int k = 0; k < n; k++) begin
            r = m_alu(l, m_rot(l), 3'(k % 5));
            if (stuck) r[0] = 1'b1;
            if (k == bad_vec) r[0] = ~r[0];
            m = {m[30:0], m[31] ^ m[21] ^ m[1] ^ m[0]} ^ r;
            l = m_lfsr(l);
        end
        return m;
    endfunction

    localparam logic [31:0] GOLD = m_sig(NV, 1'b0, -1);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a, b, alu_result, signature;
    logic [2:0]  op;
    logic        busy, done, pass;
    logic [15:0] vec_count;
    bit          stuck = 1'b0;
    bit          corrupt = 1'b0;
    int          tests = 0;
    int          fails = 0;
`ifdef ALU_BIST_GOLDEN_EN
    logic        mismatch;
    logic [15:0] fail_index;
`endif

    always #5 clk = ~clk;

    always_comb begin
        alu_result = m_alu(a, b, op);
        if (stuck) alu_result[0] = 1'b1;
        if (corrupt && vec_count == 16'd3) alu_result[0] = ~alu_result[0];
    end

    alu_bist_driver #(
        .WIDTH(32), .NUM_VECTORS(NV), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a), .b(b), .op(op), .aluResult(alu_result),
        .busy(busy), .done(done), .pass(pass), .signature(signature),
`ifdef ALU_BIST_GOLDEN_EN
        .mismatch(mismatch), .failIndex(fail_index),
`endif
        .vecCount(vec_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " a"}, a, 32'h0);
        check({tag, " b"}, b, 32'h0);
        check({tag, " op"}, 32'(op), 32'h0);
        check({tag, " busy"}, 32'(busy), 32'h0);
        check({tag, " done"}, 32'(done), 32'h0);
        check({tag, " pass"}, 32'(pass), 32'h0);
        check({tag, " sig"}, signature, 32'h0);
        check({tag, " vec"}, 32'(vec_count), 32'h0);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start busy", 32'(busy), 32'h1);
        check("start done", 32'(done), 32'h0);
    endtask

    // Entered in APPLY of vector 0, one step after the start edge.
    task automatic run_vectors(input bit pulse_v2, input logic [31:0] exp_sig, input bit exp_pass, input string tag);
        logic [31:0] l;
        l = SEED;
        for (int k = 0; k < NV; k++) begin
            if (pulse_v2 && k == 2) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            check({tag, " a"}, a, l);
            check({tag, " b"}, b, m_rot(l));
            check({tag, " op"}, 32'(op), 32'(k % 5));
            check({tag, " vec"}, 32'(vec_count), 32'(k));
            @(posedge clk);
            #1;
            l = m_lfsr(l);
            if (k < NV - 1) check({tag, " done early"}, 32'(done), 32'h0);
        end
        check({tag, " done@10"}, 32'(done), 32'h1);
        check({tag, " busy end"}, 32'(busy), 32'h0);
        check({tag, " sig"}, signature, exp_sig);
        check({tag, " pass"}, 32'(pass), 32'(exp_pass));
        check({tag, " vec end"}, 32'(vec_count), 32'(NV - 1));
        @(posedge clk);
        #1;
        check({tag, " hold done"}, 32'(done), 32'h1);
        check({tag, " hold sig"}, signature, exp_sig);
        check({tag, " hold op"}, 32'(op), 32'((NV - 1) % 5));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle busy", 32'(busy), 32'h0);

        check("vec0 a const", SEED, 32'hACE12345);
        do_start();
        run_vectors(1'b0, GOLD, 1'b1, "run1");
`ifdef ALU_BIST_GOLDEN_EN
        check("run1 mismatch", 32'(mismatch), 32'h0);
`endif

        stuck = 1'b1;
        do_start();
        run_vectors(1'b0, m_sig(NV, 1'b1, -1), 1'b0, "stuck");
        stuck = 1'b0;

        do_start();
        run_vectors(1'b1, GOLD, 1'b1, "ignore");

        do_start();
        repeat (6) @(posedge clk);
        #1;
        check("abort vec", 32'(vec_count), 32'h3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async");
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        run_vectors(1'b0, GOLD, 1'b1, "rerun");

`ifdef ALU_BIST_GOLDEN_EN
        corrupt = 1'b1;
        do_start();
        run_vectors(1'b0, m_sig(NV, 1'b0, 3), 1'b0, "golden");
        check("golden mismatch", 32'(mismatch), 32'h1);
        check("golden failIndex", 32'(fail_index), 32'h3);
        corrupt = 1'b0;
        do_start();
        check("clear mismatch", 32'(mismatch), 32'h0);
        check("clear failIndex", 32'(fail_index), 32'h0);
        run_vectors(1'b0, GOLD, 1'b1, "golden ok");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
